// File: rtl/state_sequencer.sv
// State-code sequencer for the 7-segment state decoder: free-running with a fixed
// dwell per state or single-stepped by pulse, up/down with wrap, plus change/wrap/tick strobes.
module state_sequencer #(
  parameter int unsigned NUM_STATES = 6,
  parameter int unsigned STATE_W    = 3,
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_step,
  input  logic               i_dir,
  input  logic               i_clear,
  output logic [STATE_W-1:0] o_state,
  output logic               o_changed,
  output logic               o_wrap,
  output logic               o_tick
);

  localparam int unsigned STATE_EXT_W = STATE_W + 1;

  localparam logic [CNT_W-1:0]       TICK_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [STATE_W-1:0]     STATE_LAST  = STATE_W'(NUM_STATES - 1);
  // One bit wider so NUM_STATES == 2**STATE_W does not truncate to zero.
  localparam logic [STATE_EXT_W-1:0] STATE_LIMIT = STATE_EXT_W'(NUM_STATES);

  logic [CNT_W-1:0]   presc_q, presc_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic               step_hist_q;
  logic               changed_q, changed_d;
  logic               wrap_q, wrap_d;
  logic               tick_q, tick_d;

  logic tick;
  logic step_evt;
  logic advance;
  logic state_illegal;

  assign tick          = i_en && (presc_q == TICK_LAST);
  assign step_evt      = i_step && !step_hist_q;
  assign advance       = tick || (step_evt && !i_en);
  assign state_illegal = ({1'b0, state_q} >= STATE_LIMIT);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    presc_d   = '0;
    state_d   = state_q;
    changed_d = 1'b0;
    wrap_d    = 1'b0;
    tick_d    = tick;

    // The prescaler only runs in run mode, so re-enabling always starts a full dwell.
    if (i_en && !tick) begin
      presc_d = presc_q + 1'b1;
    end

    if (i_clear) begin
      presc_d   = '0;
      state_d   = '0;
      changed_d = (state_q != '0);
    end else if (advance) begin
      changed_d = 1'b1;
      if (state_illegal) begin
        state_d = '0;
        wrap_d  = 1'b1;
      end else if (i_dir) begin
        if (state_q == STATE_LAST) begin
          state_d = '0;
          wrap_d  = 1'b1;
        end else begin
          state_d = state_q + 1'b1;
        end
      end else begin
        if (state_q == '0) begin
          state_d = STATE_LAST;
          wrap_d  = 1'b1;
        end else begin
          state_d = state_q - 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q     <= '0;
      state_q     <= '0;
      step_hist_q <= 1'b0;
      changed_q   <= 1'b0;
      wrap_q      <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      state_q     <= state_d;
      step_hist_q <= i_step;
      changed_q   <= changed_d;
      wrap_q      <= wrap_d;
      tick_q      <= tick_d;
    end
  end

  assign o_state   = state_q;
  assign o_changed = changed_q;
  assign o_wrap    = wrap_q;
  assign o_tick    = tick_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer: a vector table for the main sequences plus
// hand-written async-reset and TICK_DIV=1 sequences.
module tb_state_sequencer;

  localparam int unsigned NS = 6;
  localparam int unsigned SW = 3;
  localparam int unsigned TD = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, step = 1'b0, dir = 1'b0, clear = 1'b0;
  logic [SW-1:0] state, state2;
  logic          changed, wrap, tick;
  logic          changed2, wrap2, tick2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  state_sequencer #(.NUM_STATES(NS), .STATE_W(SW), .TICK_DIV(TD), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_step(step), .i_dir(dir), .i_clear(clear),
    .o_state(state), .o_changed(changed), .o_wrap(wrap), .o_tick(tick)
  );

  state_sequencer #(.NUM_STATES(NS), .STATE_W(SW), .TICK_DIV(1), .CNT_W(1)) dut_div1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_step(step), .i_dir(dir), .i_clear(clear),
    .o_state(state2), .o_changed(changed2), .o_wrap(wrap2), .o_tick(tick2)
  );

  typedef struct {
    int            cyc;
    logic          en, step, dir, clr;
    logic [SW-1:0] st;
    logic          chg, wrp, tck;
  } vec_t;

  vec_t vecs[$];

  // in = {en, step, dir, clear}; out = {changed, wrap, tick} expected on the last cycle.
  function automatic void add(int cyc, logic [3:0] in, logic [SW-1:0] st, logic [2:0] out);
    vec_t v;
    v.cyc = cyc;
    {v.en, v.step, v.dir, v.clr} = in;
    v.st = st;
    {v.chg, v.wrp, v.tck} = out;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] prev_st;
    int            first_edge;

    // run up through a full wrap
    add(4, 4'b1010, 3'd1, 3'b101);
    add(4, 4'b1010, 3'd2, 3'b101);
    add(4, 4'b1010, 3'd3, 3'b101);
    add(4, 4'b1010, 3'd4, 3'b101);
    add(4, 4'b1010, 3'd5, 3'b101);
    add(4, 4'b1010, 3'd0, 3'b111);
    // run down from 0
    add(4, 4'b1000, 3'd5, 3'b111);
    add(4, 4'b1000, 3'd4, 3'b101);
    // step mode: long hold gives one step, then pulses up (wrap) and down (wrap)
    add(1, 4'b0110, 3'd5, 3'b100);
    add(9, 4'b0110, 3'd5, 3'b000);
    add(1, 4'b0010, 3'd5, 3'b000);
    add(1, 4'b0110, 3'd0, 3'b110);
    add(1, 4'b0010, 3'd0, 3'b000);
    add(1, 4'b0100, 3'd5, 3'b110);
    add(1, 4'b0000, 3'd5, 3'b000);
    // step pulse at prescaler=1 while running is ignored
    add(1, 4'b1010, 3'd5, 3'b000);
    add(1, 4'b1110, 3'd5, 3'b000);
    add(2, 4'b1010, 3'd0, 3'b111);
    // climb to 3, then clear on the tick edge, clear again at 0, full dwell after
    add(4, 4'b1010, 3'd1, 3'b101);
    add(4, 4'b1010, 3'd2, 3'b101);
    add(4, 4'b1010, 3'd3, 3'b101);
    add(3, 4'b1010, 3'd3, 3'b000);
    add(1, 4'b1011, 3'd0, 3'b101);
    add(1, 4'b1011, 3'd0, 3'b000);
    add(4, 4'b1010, 3'd1, 3'b101);
    // climb to 4 for the reset-mid-dwell sequence
    add(4, 4'b1010, 3'd2, 3'b101);
    add(4, 4'b1010, 3'd3, 3'b101);
    add(4, 4'b1010, 3'd4, 3'b101);

    #12;
    check("reset state", state, 0);
    check("reset changed", changed, 0);
    check("reset wrap", wrap, 0);
    check("reset tick", tick, 0);
    #10 rst_n = 1'b1;
    #1 check("post-release state", state, 0);

    prev_st = '0;
    foreach (vecs[i]) begin
      {en, step, dir, clear} = {vecs[i].en, vecs[i].step, vecs[i].dir, vecs[i].clr};
      for (int c = 0; c < vecs[i].cyc; c++) begin
        @(posedge clk); #1;
        if (c == vecs[i].cyc - 1) begin
          check($sformatf("row%0d.c%0d state", i, c), state, vecs[i].st);
          check($sformatf("row%0d.c%0d changed", i, c), changed, vecs[i].chg);
          check($sformatf("row%0d.c%0d wrap", i, c), wrap, vecs[i].wrp);
          check($sformatf("row%0d.c%0d tick", i, c), tick, vecs[i].tck);
        end else begin
          check($sformatf("row%0d.c%0d state", i, c), state, prev_st);
          check($sformatf("row%0d.c%0d changed", i, c), changed, 0);
          check($sformatf("row%0d.c%0d wrap", i, c), wrap, 0);
          check($sformatf("row%0d.c%0d tick", i, c), tick, 0);
        end
      end
      prev_st = vecs[i].st;
    end

    // reset mid-dwell: state 4, prescaler 2, reset asserted between edges
    {en, step, dir, clear} = 4'b1010;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("mid-dwell state", state, 4);
    #3 rst_n = 1'b0;
    #1;
    check("async reset state", state, 0);
    check("async reset changed", changed, 0);
    check("async reset wrap", wrap, 0);
    check("async reset tick", tick, 0);
    #1 rst_n = 1'b1;
    first_edge = 0;
    for (int k = 1; k <= 8 && first_edge == 0; k++) begin
      @(posedge clk); #1;
      if (changed) first_edge = k;
    end
    check("first change edge after reset", first_edge, 4);
    check("state after reset dwell", state, 1);

    // TICK_DIV=1 instance: advances on every enabled edge
    {en, step, dir, clear} = 4'b1011;
    @(posedge clk); #1;
    check("div1 clear state", state2, 0);
    clear = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      check($sformatf("div1 k%0d state", k), state2, k % 6);
      check($sformatf("div1 k%0d changed", k), changed2, 1);
      check($sformatf("div1 k%0d wrap", k), wrap2, (k == 6) ? 1 : 0);
      check($sformatf("div1 k%0d tick", k), tick2, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/state_sequencer.md
Name: state_sequencer

Overview:
Drives the 3-bit state code consumed by the 7-segment state decoder. It steps through the states in order, with two modes: free-running with a fixed dwell time per state, or single-stepped by pulse. It supports up/down direction, wrap-around, and a synchronous clear. It also emits change and wrap strobes for downstream logic and test benches.

Parameters:
- NUM_STATES, 6, number of legal state codes (0..NUM_STATES-1); must be >= 2 and <= 2**STATE_W.
- STATE_W, 3, width of the state output.
- TICK_DIV, 50_000_000, clock cycles of dwell per state in run mode; must be >= 1.
- CNT_W, 26, prescaler counter width; must satisfy 2**CNT_W >= TICK_DIV.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  1 = run mode (auto-advance every TICK_DIV cycles); 0 = step mode.
- i_step  input  1  step request; level input, edge-detected internally; honoured only when i_en=0.
- i_dir  input  1  1 = count up, 0 = count down; sampled on the advance cycle.
- i_clear  input  1  synchronous clear to state 0.
- o_state  output  STATE_W  current state code, registered, always in 0..NUM_STATES-1.
- o_changed  output  1  one-cycle pulse, high in the first cycle o_state shows a new value.
- o_wrap  output  1  one-cycle pulse coincident with o_changed when the advance wrapped.
- o_tick  output  1  one-cycle pulse on the clock edge after the prescaler reaches TICK_DIV-1 (diagnostic).

Behaviour:
- Reset (i_rst_n=0, asynchronous, any time including mid-dwell):
  - o_state=0, prescaler=0, step history register=0.
  - o_changed, o_wrap and o_tick all 0.
  - Outputs hold these values until the first rising edge after release.
- Prescaler:
  - Counts 0..TICK_DIV-1 while i_en=1.
  - At TICK_DIV-1 it returns to 0 and raises the internal tick.
  - While i_en=0 it is held at 0, so re-enabling always gives a full dwell.
  - With TICK_DIV=1, a tick occurs on every enabled cycle.
- Step detect:
  - The step history register samples i_step every cycle.
  - A step event is i_step=1 AND history=0 (rising edge).
  - Holding i_step high produces exactly one step.
  - Step events while i_en=1 are discarded; they are not queued.
- Advance event = (tick AND i_en) OR (step event AND NOT i_en). On an advance:
  - If i_dir=1: next = state+1; if state = NUM_STATES-1, next = 0 and wrap is asserted.
  - If i_dir=0: next = state-1; if state = 0, next = NUM_STATES-1 and wrap is asserted.
  - o_state updates on the same clock edge that registers the advance.
  - o_changed=1 for exactly that following cycle; o_wrap=1 in the same cycle when a wrap occurred.
- i_clear (priority over advance):
  - On the edge where i_clear=1: o_state=0 and prescaler=0.
  - o_changed=1 only if o_state was non-zero before the clear; o_wrap=0.
  - The step history still samples i_step.
- Illegal state recovery: if o_state ever holds a code >= NUM_STATES (e.g. after an upset), the next advance forces it to 0 with o_changed=1 and o_wrap=1.
- Mode switching mid-dwell:
  - i_en 1->0 abandons the partial dwell; the prescaler clears.
  - i_en 0->1 starts a fresh dwell of TICK_DIV cycles.
- No combinational path from any input to any output; every output is registered.

Test Plan:
- Run-up wrap (TICK_DIV=4, NUM_STATES=6, i_en=1, i_dir=1 from reset release) -> o_state steps 0,1,2,3,4,5,0, one change every 4 cycles; o_changed pulses 6 times; o_wrap high only on the 5->0 transition.
- Run-down wrap (i_dir=0 from state 0) -> after 4 cycles o_state=5 with o_wrap=1; after another 4 cycles o_state=4 with o_wrap=0.
- Step mode (i_en=0, i_step held high for 10 cycles, then low, then pulsed high for 1 cycle; i_dir=1) -> o_state goes 0->1 once during the hold and 1->2 on the pulse; each change gives a single o_changed; o_tick never asserts.
- Step while running (i_en=1, TICK_DIV=4, i_step pulsed at prescaler=1) -> pulse ignored; the next change still occurs at the normal tick.
- Clear priority (state=3, i_clear=1 on the same edge as a tick) -> o_state=0 and o_changed=1; a second i_clear at state 0 gives o_changed=0; the next change occurs a full 4 cycles later.
- Reset mid-dwell (state=4, prescaler=2, i_rst_n pulsed low asynchronously between edges) -> o_state=0 and all pulses 0 immediately; after release, the first change occurs at the 4th enabled edge.
